// File: rtl/video_timing_pkg.sv
// video_timing_pkg: mode-table types and constants shared by the timing generator and its mode ROM.
package video_timing_pkg;
  localparam int TW = 16;
  localparam int NUM_MODES = 3;
  localparam int MODE_640X480 = 0;
  localparam int MODE_640X400 = 1;
  localparam int MODE_640X350 = 2;
  typedef struct packed {
    logic [TW-1:0] vis;
    logic [TW-1:0] front;
    logic [TW-1:0] sync;
    logic [TW-1:0] back;
    logic [TW-1:0] start;
    logic [TW-1:0] total;
  } axis_t;
  typedef struct packed {
    axis_t h;
    axis_t v;
    logic  h_pol;
    logic  v_pol;
  } timing_t;
  localparam axis_t H_640 = '{vis: TW'(640), front: TW'(16), sync: TW'(96), back: TW'(48), start: TW'(144), total: TW'(800)};
  localparam axis_t V_480 = '{vis: TW'(480), front: TW'(10), sync: TW'(2), back: TW'(33), start: TW'(35), total: TW'(525)};
  localparam axis_t V_400 = '{vis: TW'(400), front: TW'(12), sync: TW'(2), back: TW'(35), start: TW'(37), total: TW'(449)};
  localparam axis_t V_350 = '{vis: TW'(350), front: TW'(37), sync: TW'(2), back: TW'(60), start: TW'(62), total: TW'(449)};
  localparam timing_t MODE_TABLE [NUM_MODES] = '{
    '{h: H_640, v: V_480, h_pol: 1'b0, v_pol: 1'b0},
    '{h: H_640, v: V_400, h_pol: 1'b0, v_pol: 1'b1},
    '{h: H_640, v: V_350, h_pol: 1'b1, v_pol: 1'b0}
  };
endpackage

// File: rtl/video_mode_rom.sv
// video_mode_rom: mode code -> timing entry; codes without a table entry decode as mode 0.
//   mode  in   requested/active mode code
//   entry out  timing entry for that code
module video_mode_rom
  import video_timing_pkg::*;
#(
  parameter int MODE_WIDTH = 2
) (
  input  logic [MODE_WIDTH-1:0] mode,
  output timing_t               entry
);
  assign entry = (mode == MODE_WIDTH'(MODE_640X400)) ? MODE_TABLE[MODE_640X400] :
                 (mode == MODE_WIDTH'(MODE_640X350)) ? MODE_TABLE[MODE_640X350] :
                 MODE_TABLE[MODE_640X480];
endmodule

// File: rtl/video_timing_generator.sv
// video_timing_generator: multi-mode scan timing with pixel enable, frame-boundary mode switch and registered outputs.
//   clk, reset(active-low sync)        clock and reset
//   mode_req/_valid/_ready             mode-change handshake, applied at the next frame wrap
//   mode_active, pix_en                scanned mode, pixel-advance enable
//   h_pos/v_pos, h/v_visible_pos       raw and visible-relative scan positions
//   h/v_sync, h/v_blank                decoded sync (mode polarity) and blanking
//   line_start, frame_start            one-clk pulses after each line / frame wrap
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int COUNT_WIDTH = 10,
  parameter int MODE_WIDTH  = 2,
  parameter int PIX_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MODE_WIDTH-1:0]  mode_req,
  input  logic                   mode_req_valid,
  output logic                   mode_req_ready,
  output logic [MODE_WIDTH-1:0]  mode_active,
  output logic                   pix_en,
  output logic [COUNT_WIDTH-1:0] h_pos,
  output logic [COUNT_WIDTH-1:0] v_pos,
  output logic [COUNT_WIDTH-1:0] h_visible_pos,
  output logic [COUNT_WIDTH-1:0] v_visible_pos,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   h_blank,
  output logic                   v_blank,
  output logic                   line_start,
  output logic                   frame_start
);
  localparam int CW = COUNT_WIDTH;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  logic [DW-1:0]         div_q, div_d;
  logic [CW-1:0]         h_pos_q, h_pos_d, v_pos_q, v_pos_d;
  logic [CW-1:0]         h_vis_q, h_vis_d, v_vis_q, v_vis_d;
  logic [MODE_WIDTH-1:0] mode_active_q, mode_active_d, pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic                  h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic                  h_blank_q, h_blank_d, v_blank_q, v_blank_d;
  logic                  line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic                  h_end, v_end, h_wrap, f_wrap, apply, accept;
  timing_t               cur, nxt;
  logic                  unused_entry;
  // cur times the frame being scanned; nxt decodes outputs so a mode switch takes effect on the wrap edge itself
  video_mode_rom #(.MODE_WIDTH(MODE_WIDTH)) u_rom_cur (.mode(mode_active_q), .entry(cur));
  video_mode_rom #(.MODE_WIDTH(MODE_WIDTH)) u_rom_nxt (.mode(mode_active_d), .entry(nxt));
  assign unused_entry = ^{cur, nxt};
  assign pix_en = div_q == DW'(PIX_DIV - 1);
  assign h_end  = h_pos_q == CW'(cur.h.total - 1'b1);
  assign v_end  = v_pos_q == CW'(cur.v.total - 1'b1);
  assign h_wrap = pix_en && h_end;
  assign f_wrap = h_wrap && v_end;
  assign apply  = f_wrap && !ready_q;
  assign accept = mode_req_valid && ready_q;
  always_comb begin
    div_d         = pix_en ? '0 : div_q + 1'b1;
    h_pos_d       = !pix_en ? h_pos_q : h_end ? '0 : h_pos_q + 1'b1;
    v_pos_d       = !h_wrap ? v_pos_q : v_end ? '0 : v_pos_q + 1'b1;
    mode_active_d = apply ? pend_q : mode_active_q;
    pend_d        = accept ? mode_req : pend_q;
    ready_d       = accept ? 1'b0 : apply ? 1'b1 : ready_q;
    line_start_d  = h_wrap;
    frame_start_d = f_wrap;
    h_vis_d       = h_pos_d - CW'(nxt.h.start);
    v_vis_d       = v_pos_d - CW'(nxt.v.start);
    // positions before the visible start wrap to large values, so one compare covers both porches
    h_blank_d     = h_vis_d >= CW'(nxt.h.vis);
    v_blank_d     = v_vis_d >= CW'(nxt.v.vis);
    h_sync_d      = (h_pos_d < CW'(nxt.h.sync)) ~^ nxt.h_pol;
    v_sync_d      = (v_pos_d < CW'(nxt.v.sync)) ~^ nxt.v_pol;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q         <= '0;
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      mode_active_q <= '0;
      pend_q        <= '0;
      ready_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      h_vis_q       <= -CW'(MODE_TABLE[MODE_640X480].h.start);
      v_vis_q       <= -CW'(MODE_TABLE[MODE_640X480].v.start);
      h_blank_q     <= 1'b1;
      v_blank_q     <= 1'b1;
      h_sync_q      <= MODE_TABLE[MODE_640X480].h_pol;
      v_sync_q      <= MODE_TABLE[MODE_640X480].v_pol;
    end else begin
      div_q         <= div_d;
      h_pos_q       <= h_pos_d;
      v_pos_q       <= v_pos_d;
      mode_active_q <= mode_active_d;
      pend_q        <= pend_d;
      ready_q       <= ready_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      h_vis_q       <= h_vis_d;
      v_vis_q       <= v_vis_d;
      h_blank_q     <= h_blank_d;
      v_blank_q     <= v_blank_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
    end
  end
  assign mode_req_ready = ready_q;
  assign mode_active    = mode_active_q;
  assign h_pos          = h_pos_q;
  assign v_pos          = v_pos_q;
  assign h_visible_pos  = h_vis_q;
  assign v_visible_pos  = v_vis_q;
  assign h_sync         = h_sync_q;
  assign v_sync         = v_sync_q;
  assign h_blank        = h_blank_q;
  assign v_blank        = v_blank_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;
endmodule

// File: doc/video_timing_generator.md
# video_timing_generator

Parametrised, multi-mode successor to the fixed 640x480 scan generator. It replaces the derived divide-by-two clock with a single-clock pixel enable. It adds a table of selectable video modes with per-mode sync polarity, a valid/ready mode-change handshake applied only at frame boundaries, and registered sync, blank, visible-position and strobe outputs. It sits between the system clock domain and the VGA pins and line renderers.

## Interface
- COUNT_WIDTH, 10: width of all position counters and timing values.
- MODE_WIDTH, 2: width of mode codes.
- PIX_DIV, 2: system clocks per pixel; must be at least 1.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge of clk resets the block.
- mode_req  in  MODE_WIDTH  requested mode code.
- mode_req_valid  in  1  request strobe.
- mode_req_ready  out  1  high when no change is pending.
- mode_active  out  MODE_WIDTH  mode currently being scanned.
- pix_en  out  1  pixel-advance enable.
- h_pos, v_pos  out  COUNT_WIDTH  raw scan counters; 0 is the start of the sync pulse.
- h_visible_pos, v_visible_pos  out  COUNT_WIDTH  pos minus visible start, modulo 2^COUNT_WIDTH.
- h_sync, v_sync  out  1  sync at the mode's polarity.
- h_blank, v_blank  out  1  high outside the visible region.
- line_start, frame_start  out  1  one-clk pulses at a wrap.

## Operation
- Divider: counts 0..PIX_DIV-1. pix_en=1 in the cycle where count==PIX_DIV-1. With PIX_DIV=1, pix_en is constantly 1.
- Counters advance only in cycles with pix_en=1.
  - h_pos increments. At h_total-1 it wraps to 0 and v_pos increments.
  - At v_total-1 (together with h_end), v_pos wraps to 0: this is the frame wrap.
- Region order per axis: sync [0, sync_len), back porch, visible [vis_start, vis_start+vis_len), front porch, then total.
- Mode table (per axis: visible/front/sync/back; polarity "-" = active-low):
  - 0: H 640/16/96/48; V 480/10/2/33; H-, V-.
  - 1: H 640/16/96/48; V 400/12/2/35; H-, V+.
  - 2: H 640/16/96/48; V 350/37/2/60; H+, V-.
  - 3 and any code without a table entry: decodes as mode 0; mode_active still reports the requested code.
- Handshake:
  - Request is accepted when mode_req_valid && mode_req_ready. The code is latched into the pending register and ready drops.
  - On the next frame wrap, mode_active takes the pending code, counters restart at (0,0) under the new table, and ready rises.
  - A request accepted in the same cycle as a wrap is applied at the following wrap, one full frame later.
  - Requests while ready=0 are ignored.
- Strobes:
  - line_start is high for the single clk cycle after each h wrap edge.
  - frame_start is high for the single clk cycle after each frame wrap edge.
  - Neither is asserted after reset release.

## Timing
- Reset values:
  - Counters, divider, strobes: 0.
  - mode_active: 0. Pending register cleared. mode_req_ready: 1. pix_en: 0, or 1 when PIX_DIV=1.
  - h_sync, v_sync: 0 (mode 0, active-low, position 0 is in sync).
  - h_blank, v_blank: 1. h_visible_pos: -144 mod 1024. v_visible_pos: -35 mod 1024.
- Reset asserted mid-frame or mid-handshake restores all of the above at the next edge and drops any pending request.
- All outputs are registered and derived from next-state counters, so sync, blank and visible positions change on the same edge as h_pos/v_pos. There is zero-cycle skew between position and its decoded outputs.
- Mode 0, PIX_DIV=2: 800×525×2 = 840000 clk per frame. Modes 1/2: 800×449×2 = 718400 clk.
- Arithmetic is unsigned and modulo 2^COUNT_WIDTH. Totals must be at most 2^COUNT_WIDTH.

## Structure
- Package video_timing_pkg holds:
  - a timing-entry struct: vis/front/sync/back lengths per axis, derived starts and total, and two polarity bits;
  - the mode-code constants;
  - the mode-table constant.
- Sub-module video_mode_rom: combinational mode code -> timing entry, with the out-of-range code mapped to mode 0.
- The top level holds the divider, counters, handshake and output registers.

## Test plan
- Reset, then free run in mode 0 with PIX_DIV=2:
  - h_sync low for exactly 192 clk per line;
  - h_blank low for h_pos 144..783;
  - frame_start period 840000 clk;
  - v_sync low for v_pos 0..1.
- Request mode 2 mid-frame:
  - ready drops on the next edge;
  - mode_active changes on the frame-wrap edge;
  - h_sync becomes active-high;
  - v_visible_pos=0 at v_pos=62;
  - frame period becomes 718400 clk.
- Assert valid on the exact wrap cycle: mode_active is unchanged at that wrap and changes one frame later. A second request held while ready=0 is ignored.
- Request code 3: mode_active=3 after the wrap, and timing is identical to mode 0.
- PIX_DIV=1: pix_en is constantly high, and line_start has a period of 800 clk.
- Drive reset=0 mid-line with a request pending, for one edge: all outputs return to the listed reset values, the request is discarded, and the next frame runs in mode 0.
